// File: rtl/aeolus_multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the Aeolus 4-bit CPU.
// Owns PC and IR, steps FETCH/DECODE/EXECUTE/WRITEBACK and issues per-phase strobes.
module aeolus_multicycle_sequencer #(
    parameter int unsigned PC_WIDTH  = 4,
    parameter int unsigned OP_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         step,
    input  logic [OP_WIDTH-1:0]          romData,
    input  logic                         condFlag,
    output logic [PC_WIDTH-1:0]          romAddr,
    output logic [OP_WIDTH-1:0]          opcode,
    output logic [(1 << OP_WIDTH)-1:0]   execEn,
    output logic                         accLoad,
    output logic                         busy,
    output logic [1:0]                   state,
    output logic [CNT_WIDTH-1:0]         retired
);

    localparam int unsigned EXEC_WIDTH = 1 << OP_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } seq_state_e;

    seq_state_e             state_q, state_next;
    logic [PC_WIDTH-1:0]    pc_q, pc_next;
    logic [OP_WIDTH-1:0]    ir_q, ir_next;
    logic [CNT_WIDTH-1:0]   retired_q, retired_next;
    logic                   step_q;
    logic                   step_rise;
    logic [EXEC_WIDTH-1:0]  exec_en_next;
    logic                   acc_load_next;
    logic                   busy_next;
    logic [1:0]             state_dbg_next;

    // Opcodes whose result lands in the accumulator.
    function automatic logic is_alu(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(3)) || (op == OP_WIDTH'(4)) ||
               (op == OP_WIDTH'(5)) || (op == OP_WIDTH'(6)) ||
               (op >= OP_WIDTH'(10));
    endfunction

    function automatic logic is_skip(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(8)) || (op == OP_WIDTH'(9));
    endfunction

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            step_q    <= 1'b0;
            execEn    <= '0;
            accLoad   <= 1'b0;
            busy      <= 1'b0;
            state     <= 2'd0;
        end else begin
            state_q   <= state_next;
            pc_q      <= pc_next;
            ir_q      <= ir_next;
            retired_q <= retired_next;
            step_q    <= step;
            execEn    <= exec_en_next;
            accLoad   <= acc_load_next;
            busy      <= busy_next;
            state     <= state_dbg_next;
        end
    end

    always_comb begin
        state_next     = state_q;
        pc_next        = pc_q;
        ir_next        = ir_q;
        retired_next   = retired_q;
        exec_en_next   = '0;
        acc_load_next  = 1'b0;
        busy_next      = 1'b0;
        state_dbg_next = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (run || step_rise) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ir_next    = romData;
                pc_next    = pc_q + PC_WIDTH'(1);
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_skip(ir_q) && condFlag) begin
                    pc_next = pc_q + PC_WIDTH'(1);
                end
                state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retired_next = retired_q + CNT_WIDTH'(1);
                state_next   = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Strobes are registered one phase ahead so they align with the state they belong to.
        if (state_next == S_EXECUTE) begin
            exec_en_next = EXEC_WIDTH'(1) << ir_next;
        end
        acc_load_next = (state_next == S_WRITEBACK) && is_alu(ir_next);
        busy_next     = (state_next != S_IDLE);

        unique case (state_next)
            S_IDLE:   state_dbg_next = 2'd0;
            S_FETCH:  state_dbg_next = 2'd1;
            S_DECODE: state_dbg_next = 2'd2;
            default:  state_dbg_next = 2'd3;
        endcase
    end

    assign romAddr = pc_q;
    assign opcode  = ir_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_aeolus_multicycle_sequencer.sv
// Self-checking bench for aeolus_multicycle_sequencer against an instruction-level model.
module tb_aeolus_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [3:0]  romData;
    logic        condFlag;
    logic [3:0]  romAddr;
    logic [3:0]  opcode;
    logic [15:0] execEn;
    logic        accLoad;
    logic        busy;
    logic [1:0]  state;
    logic [7:0]  retired;

    logic [3:0]  rom [16];
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  m_pc;
    logic [7:0]  m_ret;

    aeolus_multicycle_sequencer #(
        .PC_WIDTH (4),
        .OP_WIDTH (4),
        .CNT_WIDTH(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .step    (step),
        .romData (romData),
        .condFlag(condFlag),
        .romAddr (romAddr),
        .opcode  (opcode),
        .execEn  (execEn),
        .accLoad (accLoad),
        .busy    (busy),
        .state   (state),
        .retired (retired)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always_ff @(posedge clk) romData <= rom[romAddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_alu(input logic [3:0] op);
        return (op inside {4'h3, 4'h4, 4'h5, 4'h6}) || (op >= 4'hA);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction starting from IDLE (with run/step) or from the previous WRITEBACK.
    task automatic exec_one(input bit cond, input bit drop_run);
        logic [3:0]  op;
        logic [3:0]  npc;
        logic [15:0] oh;
        tick();
        check("fetch_state", 32'(state), 32'd1);
        check("fetch_addr", 32'(romAddr), 32'(m_pc));
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_retired", 32'(retired), 32'(m_ret));
        op = rom[m_pc];
        tick();
        check("decode_state", 32'(state), 32'd2);
        check("decode_exec", 32'(execEn), 32'd0);
        if (drop_run) run = 1'b0;
        tick();
        oh = '0;
        oh[op] = 1'b1;
        check("exec_state", 32'(state), 32'd3);
        check("exec_opcode", 32'(opcode), 32'(op));
        check("exec_en", 32'(execEn), 32'(oh));
        check("exec_acc", 32'(accLoad), 32'd0);
        npc = m_pc + 4'd1;
        check("exec_pc", 32'(romAddr), 32'(npc));
        condFlag = cond;
        tick();
        if ((op == 4'h8 || op == 4'h9) && cond) npc = npc + 4'd1;
        m_pc  = npc;
        m_ret = m_ret + 8'd1;
        condFlag = 1'b0;
        check("wb_state", 32'(state), 32'd3);
        check("wb_exec", 32'(execEn), 32'd0);
        check("wb_acc", 32'(accLoad), 32'(ref_alu(op)));
        check("wb_pc", 32'(romAddr), 32'(m_pc));
    endtask

    task automatic check_idle();
        tick();
        check("idle_state", 32'(state), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pc", 32'(romAddr), 32'(m_pc));
        check("idle_retired", 32'(retired), 32'(m_ret));
        check("idle_exec", 32'(execEn), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        run      = 1'b0;
        step     = 1'b0;
        condFlag = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
        rom[0]  = 4'h0;
        rom[1]  = 4'h1;
        rom[2]  = 4'hA;
        rom[3]  = 4'h2;
        rom[4]  = 4'h7;
        rom[5]  = 4'h8;
        rom[14] = 4'hB;
        rom[15] = 4'h9;
        m_pc  = 4'd0;
        m_ret = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 32'(romAddr), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_exec", 32'(execEn), 32'd0);
        check("rst_acc", 32'(accLoad), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;

        // LDA, LDB, ADD, LDO, CLR then SNZA at 5 taken: next fetch from 7.
        for (int k = 0; k < 6; k++) exec_one(k == 5, 1'b0);

        // Random run up to SNZS at 15, taken: wraps to 1.
        for (int n = 0; n < 20 && m_pc != 4'd15; n++) exec_one(1'($urandom), 1'b0);
        exec_one(1'b1, 1'b0);

        // Non-skip at 15 wraps to 0.
        rom[15] = 4'hA;
        for (int n = 0; n < 20 && m_pc != 4'd15; n++) exec_one(1'($urandom), 1'b0);
        exec_one(1'($urandom), 1'b0);

        // SNZA at 5 not taken: next fetch from 6.
        rom[5] = 4'h8;
        for (int n = 0; n < 20 && m_pc != 4'd5; n++) exec_one(1'b0, 1'b0);
        exec_one(1'b0, 1'b0);
        exec_one(1'($urandom), 1'b0);

        // Run dropped during DECODE: instruction completes, then IDLE with PC retained.
        exec_one(1'b0, 1'b1);
        repeat (3) check_idle();

        // Held step runs exactly one instruction.
        step = 1'b1;
        exec_one(1'($urandom), 1'b0);
        repeat (16) check_idle();
        step = 1'b0;
        check_idle();

        // Async reset in EXECUTE aborts with no writeback.
        run = 1'b1;
        repeat (3) tick();
        check("pre_rst_state", 32'(state), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("abort_exec", 32'(execEn), 32'd0);
        check("abort_addr", 32'(romAddr), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("abort_acc", 32'(accLoad), 32'd0);
        end
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_pc  = 4'd0;
        m_ret = 8'd0;
        check_idle();
        run = 1'b1;
        exec_one(1'b0, 1'b0);
        exec_one(1'b0, 1'b1);
        check_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aeolus_multicycle_sequencer.md
Name: aeolus_multicycle_sequencer

Overview:
- Multi-cycle control FSM for the Aeolus 4-bit CPU. Replaces the free-running PC and increment adder.
- Owns the PC and the instruction register. Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK and issues one-cycle strobes to the register file, ALU, accumulator and output register.
- Handles conditional skips (SNZA/SNZS), run/single-step control and retired-instruction counting.

Parameters:
- PC_WIDTH, 4, program counter and ROM address width.
- OP_WIDTH, 4, opcode width.
- CNT_WIDTH, 8, retired-instruction counter width.

Ports:
- clk  in  1  system clock (divided CPU clock).
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = continuous execution.
- step  in  1  single-step request; rising edge sampled.
- romData  in  OP_WIDTH  opcode from synchronous ROM; valid 1 cycle after romAddr.
- condFlag  in  1  skip condition from ALU, sampled in EXECUTE.
- romAddr  out  PC_WIDTH  current PC, drives ROM address.
- opcode  out  OP_WIDTH  instruction register contents.
- execEn  out  16  one-hot strobe, bit = opcode, high only in EXECUTE.
- accLoad  out  1  accumulator load enable, WRITEBACK of ALU-class ops only.
- busy  out  1  high in any state except IDLE.
- state  out  2  IDLE/FETCH encoding for debug: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE; WRITEBACK reported as 3.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- Reset (async) values: PC=0, IR=0, state IDLE, execEn=0, accLoad=0, busy=0, retired=0, step edge register=0.
- Opcode map: 0 LDA, 1 LDB, 2 LDO, 3 LDSA, 4 LDSB, 5 LSH, 6 RSH, 7 CLR, 8 SNZA, 9 SNZS, A ADD, B SUB, C AND, D OR, E XOR, F INV.
- ALU class (accLoad in WRITEBACK): opcodes 3,4,5,6,A,B,C,D,E,F.
- IDLE:
  - Go to FETCH if run=1.
  - Otherwise go to FETCH if step rises (step=1 and previous step=0).
  - run has priority; a held step triggers exactly one instruction.
- FETCH: romAddr=PC. Always go to DECODE next.
- DECODE: IR <= romData; PC <= PC+1, wrapping modulo 2^PC_WIDTH (15 -> 0). Go to EXECUTE.
- EXECUTE:
  - execEn[IR]=1 for exactly this cycle.
  - If IR is 8 or 9 and condFlag=1: PC <= PC+1 (skip next instruction; wrap applies, e.g. 15 -> 0).
  - condFlag is ignored for all other opcodes.
  - Go to WRITEBACK.
- WRITEBACK:
  - accLoad=1 if IR is ALU class.
  - retired <= retired+1, wrapping.
  - Next state is FETCH if run=1, else IDLE.
- Latency: every instruction takes exactly 4 cycles, FETCH to WRITEBACK inclusive. Back-to-back under run gives 1 instruction per 4 clocks.
- Clearing run mid-instruction: the current instruction completes; the block stops in IDLE after WRITEBACK. The PC is retained.
- step while busy: ignored. The edge register still tracks step, so no stale edge is left pending.
- All outputs are glitch-free and registered or decoded from registered state. Only one of execEn/accLoad is ever active in any cycle.
- Reset asserted in any state aborts immediately to the reset values. No partial writeback occurs.

Test Plan:
- Reset, then run=1 with ROM[0..3]=0,1,A,2:
  - execEn bits 0, 1, 10, 2 appear at cycles 3, 7, 11, 15 after release.
  - accLoad pulses only for ADD.
  - retired=4 after 16 cycles.
- ROM[5]=8, condFlag=1 in EXECUTE: the next fetch address is 7 and 6 is skipped. Repeat with condFlag=0: the next fetch address is 6.
- Wrap: PC=15 holding SNZS with condFlag=1: the next fetch address is 1. A non-skip instruction at 15: the next fetch address is 0.
- Single step, run=0: hold step high for 20 cycles. Exactly one instruction executes (retired +1) and the block returns to IDLE with busy=0.
- Run dropped during DECODE: EXECUTE and WRITEBACK still occur, then IDLE. romAddr holds the next PC.
- Async reset asserted during EXECUTE: execEn drops to 0 immediately, PC=0 and retired=0. accLoad is never asserted for the aborted instruction.
